// File: rtl/cpu_pkg.sv
// Shared core types: memory-arbiter FSM states, access owner encoding and
// the full-word byte-enable mask.
package cpu_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        OWNER_IF,
        OWNER_DM
    } arb_owner_t;

    localparam logic [3:0] MEM_BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant logic for mem_arbiter: data has priority unless fetch
// has already waited through STARVE_LIMIT consecutive data grants.
module mem_arb_grant #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned SC_W         = 3
) (
    input  logic            free,
    input  logic            if_req_valid,
    input  logic            dm_req_valid,
    input  logic [SC_W-1:0] starve_cnt,
    output logic            grant_if,
    output logic            grant_dm
);

    always_comb begin
        grant_if = free && if_req_valid &&
                   (!dm_req_valid || (starve_cnt == SC_W'(STARVE_LIMIT)));
        grant_dm = free && dm_req_valid && !grant_if;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter in front of a single-port fixed-latency memory.
// Define MEM_ARB_PERF_EN to add the saturating stall counters perf_*_stall_cnt.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              dm_req_valid,
    output logic              dm_req_ready,
    input  logic [ADDR_W-1:0] dm_req_addr,
    input  logic              dm_req_we,
    input  logic [DATA_W-1:0] dm_req_wdata,
    input  logic [3:0]        dm_req_be,
    output logic              dm_rsp_valid,
    output logic [DATA_W-1:0] dm_rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       perf_if_stall_cnt,
    output logic [31:0]       perf_dm_stall_cnt,
`endif
    output logic              busy
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state_q, state_d;
    arb_owner_t       owner_q, owner_d;
    logic             owner_we_q, owner_we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SC_W-1:0]  starve_q, starve_d;
    logic             free, rsp_cycle, grant_if, grant_dm;

    // Gated by rst_n so no strobe or ready escapes while reset is held.
    assign free = rst_n && ((state_q == ARB_IDLE) ||
                            ((state_q == ARB_WAIT) && (cnt_q == '0)));

    mem_arb_grant #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .SC_W        (SC_W)
    ) u_grant (
        .free        (free),
        .if_req_valid(if_req_valid),
        .dm_req_valid(dm_req_valid),
        .starve_cnt  (starve_q),
        .grant_if    (grant_if),
        .grant_dm    (grant_dm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWNER_IF;
            owner_we_q <= 1'b0;
            cnt_q      <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_we_q <= owner_we_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_we_d = owner_we_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;

        if (grant_if || grant_dm) begin
            state_d    = ARB_WAIT;
            cnt_d      = CNT_W'(MEM_LATENCY - 1);
            owner_d    = grant_dm ? OWNER_DM : OWNER_IF;
            owner_we_d = grant_dm && dm_req_we;
        end else if (state_q == ARB_WAIT) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                state_d = ARB_IDLE;
            end
        end

        if (!if_req_valid || grant_if) begin
            starve_d = '0;
        end else if (grant_dm && (starve_q != SC_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    always_comb begin
        if_req_ready = grant_if;
        dm_req_ready = grant_dm;
        mem_en       = grant_if || grant_dm;
        mem_we       = grant_dm && dm_req_we;
        mem_addr     = grant_dm ? dm_req_addr : (grant_if ? if_req_addr : '0);
        mem_wdata    = grant_dm ? dm_req_wdata : '0;
        mem_be       = grant_dm ? dm_req_be : (grant_if ? MEM_BE_ALL : '0);

        rsp_cycle    = (state_q == ARB_WAIT) && (cnt_q == '0);
        if_rsp_valid = rsp_cycle && (owner_q == OWNER_IF);
        dm_rsp_valid = rsp_cycle && (owner_q == OWNER_DM);
        if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
        dm_rsp_data  = (dm_rsp_valid && !owner_we_q) ? mem_rdata : '0;
        busy         = (state_q == ARB_WAIT);
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_stall_cnt <= '0;
            perf_dm_stall_cnt <= '0;
        end else begin
            if (if_req_valid && !grant_if && (perf_if_stall_cnt != '1)) begin
                perf_if_stall_cnt <= perf_if_stall_cnt + 32'd1;
            end
            if (dm_req_valid && !grant_dm && (perf_dm_stall_cnt != '1)) begin
                perf_dm_stall_cnt <= perf_dm_stall_cnt + 32'd1;
            end
        end
    end
`endif

    // Requester contract: a pending request stays valid and unchanged until accepted.
    a_if_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (if_req_valid && !if_req_ready) |=> (if_req_valid && $stable(if_req_addr)));

    a_dm_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (dm_req_valid && !dm_req_ready) |=>
            (dm_req_valid && $stable({dm_req_addr, dm_req_we, dm_req_wdata, dm_req_be})));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter at MEM_LATENCY=2, STARVE_LIMIT=4, driving a
// behavioural memory macro; with MEM_ARB_PERF_EN the stall counters are also checked.
module tb_mem_arbiter;

    localparam int ML = 2;
    localparam int SL = 4;

    typedef struct { int due; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] be; } dm_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        dm_req_valid, dm_req_ready, dm_req_we, dm_rsp_valid;
    logic [31:0] dm_req_addr, dm_req_wdata, dm_rsp_data;
    logic [3:0]  dm_req_be, mem_be;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall_cnt, perf_dm_stall_cnt;
    logic [31:0] perf_if_exp, perf_dm_exp;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MEM_LATENCY (ML),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_req_valid     (if_req_valid),
        .if_req_ready     (if_req_ready),
        .if_req_addr      (if_req_addr),
        .if_rsp_valid     (if_rsp_valid),
        .if_rsp_data      (if_rsp_data),
        .dm_req_valid     (dm_req_valid),
        .dm_req_ready     (dm_req_ready),
        .dm_req_addr      (dm_req_addr),
        .dm_req_we        (dm_req_we),
        .dm_req_wdata     (dm_req_wdata),
        .dm_req_be        (dm_req_be),
        .dm_rsp_valid     (dm_rsp_valid),
        .dm_rsp_data      (dm_rsp_data),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_be           (mem_be),
        .mem_rdata        (mem_rdata),
`ifdef MEM_ARB_PERF_EN
        .perf_if_stall_cnt(perf_if_stall_cnt),
        .perf_dm_stall_cnt(perf_dm_stall_cnt),
`endif
        .busy             (busy)
    );

    // Memory macro: 256 words, read data appears ML cycles after the strobe.
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] rd_pipe [0:ML-1];

    always @(posedge clk) begin
        for (int i = ML - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_en && !mem_we) rd_pipe[0] <= mem[mem_addr[9:2]];
        else                   rd_pipe[0] <= $urandom;
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    assign mem_rdata = rd_pipe[ML-1];

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: arbiter is free ML cycles after its last grant.
    int          last_grant = -1000;
    int          starve = 0;
    bit          if_hs = 0, dm_hs = 0;
    exp_t        if_exp[$];
    exp_t        dm_exp[$];
    logic [31:0] last_dm_rsp = '0;

    always @(negedge clk) begin
        bit free, g_if, g_dm;
        int idx;
        logic [31:0] w;
        if (!rst_n) begin
            chk("rst_if_ready", if_req_ready, 0);
            chk("rst_dm_ready", dm_req_ready, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_busy", busy, 0);
            last_grant = -1000;
            starve = 0;
            if_hs = 0;
            dm_hs = 0;
`ifdef MEM_ARB_PERF_EN
            chk("rst_perf_if", perf_if_stall_cnt, 0);
            chk("rst_perf_dm", perf_dm_stall_cnt, 0);
            perf_if_exp = 0;
            perf_dm_exp = 0;
`endif
        end else begin
            free = (cyc >= last_grant + ML);
            g_if = free && if_req_valid && (!dm_req_valid || starve == SL);
            g_dm = free && dm_req_valid && !g_if;
            chk("if_ready", if_req_ready, g_if);
            chk("dm_ready", dm_req_ready, g_dm);
            chk("mem_en", mem_en, g_if || g_dm);
            chk("busy", busy, (cyc > last_grant) && (cyc <= last_grant + ML));
`ifdef MEM_ARB_PERF_EN
            chk("perf_if", perf_if_stall_cnt, perf_if_exp);
            chk("perf_dm", perf_dm_stall_cnt, perf_dm_exp);
            if (if_req_valid && !g_if) perf_if_exp++;
            if (dm_req_valid && !g_dm) perf_dm_exp++;
`endif
            if (g_if) begin
                chk("if_mem_addr", mem_addr, if_req_addr);
                chk("if_mem_we", mem_we, 0);
                chk("if_mem_be", mem_be, 4'hF);
                if_exp.push_back(exp_t'{cyc + ML, ref_mem[widx(if_req_addr)]});
                last_grant = cyc;
                if_hs = 1;
            end else if (g_dm) begin
                idx = widx(dm_req_addr);
                chk("dm_mem_addr", mem_addr, dm_req_addr);
                chk("dm_mem_we", mem_we, dm_req_we);
                chk("dm_mem_be", mem_be, dm_req_be);
                if (dm_req_we) begin
                    chk("dm_mem_wdata", mem_wdata, dm_req_wdata);
                    w = ref_mem[idx];
                    for (int b = 0; b < 4; b++)
                        if (dm_req_be[b]) w[b*8 +: 8] = dm_req_wdata[b*8 +: 8];
                    ref_mem[idx] = w;
                    dm_exp.push_back(exp_t'{cyc + ML, 32'h0});
                end else begin
                    dm_exp.push_back(exp_t'{cyc + ML, ref_mem[idx]});
                end
                last_grant = cyc;
                dm_hs = 1;
            end else begin
                chk("idle_mem_we", mem_we, 0);
                chk("idle_mem_be", mem_be, 0);
            end
            if (!if_req_valid || g_if)   starve = 0;
            else if (g_dm && starve < SL) starve++;
        end
    end

    // Response monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_if_rsp_valid", if_rsp_valid, 0);
            chk("rst_dm_rsp_valid", dm_rsp_valid, 0);
            if_exp.delete();
            dm_exp.delete();
        end else begin
            if (if_rsp_valid) begin
                chk("if_rsp_expected", if_exp.size() > 0, 1);
                if (if_exp.size() > 0) begin
                    e = if_exp.pop_front();
                    chk("if_rsp_cycle", cyc, e.due);
                    chk("if_rsp_data", if_rsp_data, e.data);
                end
            end else begin
                chk("if_rsp_idle_data", if_rsp_data, 0);
                chk("if_rsp_missing", (if_exp.size() > 0) && (if_exp[0].due <= cyc), 0);
                if ((if_exp.size() > 0) && (if_exp[0].due <= cyc)) void'(if_exp.pop_front());
            end
            if (dm_rsp_valid) begin
                last_dm_rsp = dm_rsp_data;
                chk("dm_rsp_expected", dm_exp.size() > 0, 1);
                if (dm_exp.size() > 0) begin
                    e = dm_exp.pop_front();
                    chk("dm_rsp_cycle", cyc, e.due);
                    chk("dm_rsp_data", dm_rsp_data, e.data);
                end
            end else begin
                chk("dm_rsp_idle_data", dm_rsp_data, 0);
                chk("dm_rsp_missing", (dm_exp.size() > 0) && (dm_exp[0].due <= cyc), 0);
                if ((dm_exp.size() > 0) && (dm_exp[0].due <= cyc)) void'(dm_exp.pop_front());
            end
        end
    end

    logic [31:0] if_src[$];
    dm_t         dm_src[$];

    task automatic drive_cycle(output bit if_done, output bit dm_done);
        dm_t d;
        @(posedge clk);
        #1;
        if_done = if_hs;
        dm_done = dm_hs;
        if (if_hs) begin if_hs = 0; if_req_valid = 1'b0; end
        if (dm_hs) begin dm_hs = 0; dm_req_valid = 1'b0; end
        if (!if_req_valid && if_src.size() > 0) begin
            if_req_addr  = if_src.pop_front();
            if_req_valid = 1'b1;
        end
        if (!dm_req_valid && dm_src.size() > 0) begin
            d = dm_src.pop_front();
            dm_req_addr  = d.addr;
            dm_req_we    = d.we;
            dm_req_wdata = d.wdata;
            dm_req_be    = d.be;
            dm_req_valid = 1'b1;
        end
    endtask

    task automatic drain(input int max_cyc, input string name);
        int n = 0;
        bit a, b;
        while ((if_src.size() > 0 || dm_src.size() > 0 || if_req_valid || dm_req_valid ||
                if_exp.size() > 0 || dm_exp.size() > 0) && n < max_cyc) begin
            drive_cycle(a, b);
            n++;
        end
        chk({name, "_drain_in_time"}, n < max_cyc, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  n;
        bit  a, b;
        dm_t d;
        if_req_valid = 0; if_req_addr = '0;
        dm_req_valid = 0; dm_req_addr = '0; dm_req_we = 0; dm_req_wdata = '0; dm_req_be = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[128]     = '0;
        ref_mem[128] = '0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fetch-only stream.
        if_src.push_back(32'h0);
        if_src.push_back(32'h4);
        if_src.push_back(32'h8);
        drain(40, "fetch_stream");

        // Simultaneous load and fetch: data first.
        dm_src.push_back(dm_t'{32'h100, 1'b0, 32'h0, 4'h0});
        if_src.push_back(32'h10);
        drain(40, "simultaneous");

        // Partial store then load of the same word.
        dm_src.push_back(dm_t'{32'h200, 1'b1, 32'hDEADBEEF, 4'b0011});
        dm_src.push_back(dm_t'{32'h200, 1'b0, 32'h0, 4'h0});
        drain(40, "store_load");
        chk("store_then_load_value", last_dm_rsp, 32'h0000BEEF);

        // Both requesters saturated: starvation guard.
        for (int i = 0; i < 6; i++) if_src.push_back(32'h40 + 32'(i * 4));
        for (int i = 0; i < 24; i++) dm_src.push_back(dm_t'{32'h80 + 32'(i * 4), 1'b0, 32'h0, 4'h0});
        drain(200, "starvation");

        // Reset one cycle after a load accept: response is dropped.
        dm_src.push_back(dm_t'{32'h300, 1'b0, 32'h0, 4'h0});
        n = 0;
        b = 0;
        while (!b && n < 20) begin
            drive_cycle(a, b);
            n++;
        end
        chk("mid_reset_load_accepted", b, 1);
        rst_n = 1'b0;
        if_req_addr  = 32'h44;
        if_req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_first_accept", if_req_ready, 1);
        drain(40, "post_reset");

        // Random traffic over a shared 32-word window.
        repeat (600) begin
            if (if_src.size() == 0 && $urandom_range(0, 2) != 0)
                if_src.push_back({22'h0, 8'($urandom_range(0, 31)), 2'b00});
            if (dm_src.size() == 0 && $urandom_range(0, 2) != 0) begin
                d.addr  = {22'h0, 8'($urandom_range(0, 31)), 2'b00};
                d.we    = 1'($urandom_range(0, 1));
                d.wdata = $urandom;
                d.be    = 4'($urandom);
                dm_src.push_back(d);
            end
            drive_cycle(a, b);
        end
        drain(100, "random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
